// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//
// Purpose:
//   Accepts one register-to-register command at a time and steps it through
//   IDLE -> EXEC -> RESP. It reads operands from an 8-entry register file and
//   presents them, registered, to an external combinational ALU. It captures
//   the ALU result (or the immediate for LOAD) and writes it back. The result
//   is then held on a valid/ready response port until the consumer takes it.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake (ready only in IDLE, out of reset)
//   cmd_op              0 ADD, 1 SUB, 2 LOAD, 3 AND, 4 OR, 5 XOR, 6 NOT, 7 illegal
//   cmd_rd/ra/rb        destination / source register indices
//   cmd_imm             immediate for LOAD
//   alu_A/alu_B         registered ALU operands
//   alu_ctrl            registered ALU control word (the opcode)
//   alu_X               combinational ALU result
//   res_valid/ready     response handshake
//   res_data/rd         captured result and its destination index
//   res_zero/err        result-is-zero flag, illegal-opcode flag
// ---------------------------------------------------------------------------
module alu_sequencer #(
    parameter int bits = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic [2:0]      cmd_rd,
    input  logic [2:0]      cmd_ra,
    input  logic [2:0]      cmd_rb,
    input  logic [bits-1:0] cmd_imm,
    output logic [bits-1:0] alu_A,
    output logic [bits-1:0] alu_B,
    output logic [2:0]      alu_ctrl,
    input  logic [bits-1:0] alu_X,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [bits-1:0] res_data,
    output logic [2:0]      res_rd,
    output logic            res_zero,
    output logic            res_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_LOAD    = 3'd2;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [2:0]      rd_q, rd_d;
    logic [bits-1:0] imm_q, imm_d;
    logic [bits-1:0] alu_a_q, alu_a_d;
    logic [bits-1:0] alu_b_q, alu_b_d;
    logic [2:0]      alu_ctrl_q, alu_ctrl_d;
    logic            res_valid_q, res_valid_d;
    logic [bits-1:0] res_data_q, res_data_d;
    logic [2:0]      res_rd_q, res_rd_d;
    logic            res_zero_q, res_zero_d;
    logic            res_err_q, res_err_d;
    logic [bits-1:0] rf_q [8];
    logic [bits-1:0] rf_d [8];
    logic [bits-1:0] result;

    // r0 is hard-wired to zero regardless of what the array holds.
    function automatic logic [bits-1:0] rf_read(input logic [bits-1:0] rf [8],
                                                input logic [2:0] idx);
        return (idx == 3'd0) ? '0 : rf[idx];
    endfunction

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign alu_A     = alu_a_q;
    assign alu_B     = alu_b_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_rd    = res_rd_q;
    assign res_zero  = res_zero_q;
    assign res_err   = res_err_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rd_d        = rd_q;
        imm_d       = imm_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_ctrl_d  = alu_ctrl_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_rd_d    = res_rd_q;
        res_zero_d  = res_zero_q;
        res_err_d   = res_err_q;
        rf_d        = rf_q;

        // Result selection for the command held in EXEC.
        case (op_q)
            OP_LOAD:    result = imm_q;
            OP_ILLEGAL: result = '0;
            default:    result = alu_X;
        endcase

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d       = cmd_op;
                    rd_d       = cmd_rd;
                    imm_d      = cmd_imm;
                    alu_a_d    = rf_read(rf_q, cmd_ra);
                    alu_b_d    = rf_read(rf_q, cmd_rb);
                    alu_ctrl_d = cmd_op;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                res_data_d  = result;
                res_rd_d    = rd_q;
                res_zero_d  = (result == '0);
                res_err_d   = (op_q == OP_ILLEGAL);
                res_valid_d = 1'b1;
                if ((op_q != OP_ILLEGAL) && (rd_q != 3'd0)) begin
                    rf_d[rd_q] = result;
                end
                state_d = RESP;
            end
            RESP: begin
                // Response fields are left untouched; only valid drops on handshake.
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctrl_q  <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
            res_zero_q  <= 1'b0;
            res_err_q   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_ctrl_q  <= alu_ctrl_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_rd_q    <= res_rd_d;
            res_zero_q  <= res_zero_d;
            res_err_q   <= res_err_d;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

endmodule
